gon_row_collector: RTL and testbench
====================================

# gon_row_collector

Collects partial-sum beats from one row of PEs on the Global Output Network (GON) and forwards them, one beat at a time, to the vertical GON bus toward the GLB. It sits directly downstream of the per-PE GON multicast controllers. Those controllers gate each PE's valid by tag match; this block receives the gated valid vector, selects the sourcing PE, buffers the beat in a 2-entry FIFO and broadcasts a single ready back to all controllers. A configured transfer length is counted, and completion is signalled after the FIFO has fully drained.

## Interface
- NUM_PE, 8, PEs (multicast controllers) on this row
- DATA_SIZE, 32, psum beat width
- LEN_BITS, 16, width of the transfer-length counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a transfer; sampled only in IDLE
- len  in  LEN_BITS  number of beats to collect; sampled with start
- valid_vec  in  NUM_PE  per-PE valid from the multicast controllers (bit i = PE i)
- data_vec  in  NUM_PE*DATA_SIZE  per-PE psum; PE i occupies bits [i*DATA_SIZE +: DATA_SIZE]
- ready_out  out  1  broadcast ready to every controller's ready_in
- valid_out  out  1  beat available to the Y-bus
- data_out  out  DATA_SIZE  head-of-FIFO beat
- ready_in  in  1  Y-bus ready
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle completion pulse
- err  out  1  sticky flag: more than one valid_vec bit high at an accept

## Operation
- FSM states:
  - IDLE: on start with len>0, load remaining=len, clear err, go to RUN. On start with len==0, pulse done on the next cycle and stay in IDLE.
  - RUN: accept beats until remaining reaches 0, then go to DRAIN.
  - DRAIN: when the FIFO is empty, pulse done and return to IDLE.
- start is ignored in RUN and DRAIN.
- ready_out = (state==RUN) && (fifo_count<2) && (remaining!=0). It is a function of registered state only; there is no combinational path from ready_in or valid_vec.
- Accept occurs when ready_out && |valid_vec:
  - Push the data of the lowest-index asserted PE.
  - Decrement remaining.
  - If popcount(valid_vec) > 1, set err. The beat is still accepted.
- FIFO: 2 entries with a head pointer, a tail pointer and a 2-bit count.
  - Pop occurs when valid_out && ready_in.
  - Push and pop in the same cycle leave count unchanged.
- valid_out = (fifo_count!=0). data_out = head entry. data_out holds its value while valid_out && !ready_in.
- err is cleared only by rst or by an accepted start.
- rst mid-transfer: FIFO contents are dropped, state returns to IDLE, and no done pulse is generated.

## Timing
- Reset values: ready_out 0, valid_out 0, data_out 0, busy 0, done 0, err 0, state IDLE, fifo_count 0, remaining 0.
- start→RUN takes 1 cycle: ready_out can first be high the cycle after start.
- Accept→valid_out latency is 1 cycle.
- Throughput is 1 beat/cycle sustained while ready_in stays high (count oscillates 0→1 and holds at 1).
- With ready_in low, at most 2 beats are accepted; ready_out drops the cycle after the second push.
- In the cycle of the final accept, remaining becomes 0 at the edge and the FSM enters DRAIN; ready_out is low from the next cycle.
- done is registered. It is high for exactly one cycle, the cycle after the edge at which fifo_count reaches 0 while in DRAIN. busy falls in the same cycle done rises.
- For len==0, done is high the cycle after start, and busy never rises.

## Test plan
- Single-PE stream: len=4, valid_vec=8'b0000_0100 continuously, data 1..4, ready_in=1. Required: data_out sequence 1,2,3,4 on 4 consecutive cycles; err=0; done high exactly one cycle, 1 cycle after the last pop.
- Backpressure: len=3, ready_in=0 for 6 cycles then 1. Required: exactly 2 accepts, then ready_out low; data_out stable at beat 1 while stalled; all 3 beats delivered in order once released; done after the third pop.
- Conflict: valid_vec=8'b1001_0000 with data PE4=0xA, PE7=0xB. Required: 0xA pushed; err=1 and sticky through done; err cleared by the next start.
- len=0 start. Required: done pulses the cycle after start; busy, ready_out and valid_out stay 0.
- Reset mid-transfer: len=5, 2 beats buffered with ready_in=0, then rst pulsed. Required: all outputs at reset values immediately (asynchronous); no done pulse; a new start with len=1 completes normally.
- start while busy. Required: ignored; remaining and err unchanged; transfer completes with the original len.

Source files
------------

// File: rtl/gon_row_collector.sv
// gon_row_collector: gathers GON psum beats from one PE row through a 2-entry FIFO
// and forwards them to the vertical GON bus, counting a configured transfer length.
module gon_row_collector #(
    parameter int NUM_PE    = 8,
    parameter int DATA_SIZE = 32,
    parameter int LEN_BITS  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_BITS-1:0]         len,
    input  logic [NUM_PE-1:0]           valid_vec,
    input  logic [NUM_PE*DATA_SIZE-1:0] data_vec,
    output logic                        ready_out,
    output logic                        valid_out,
    output logic [DATA_SIZE-1:0]        data_out,
    input  logic                        ready_in,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [LEN_BITS-1:0]   r_remaining;
    logic [DATA_SIZE-1:0]  r_mem [2];
    logic                  r_head, r_tail;
    logic [1:0]            r_count, w_count_nxt;
    logic                  r_done, r_err, w_done_nxt;
    logic                  w_accept, w_pop, w_multi, w_load;
    logic [DATA_SIZE-1:0]  w_sel;

    assign ready_out   = (r_state == RUN) && (r_count < 2'd2) && (r_remaining != '0);
    assign w_accept    = ready_out && |valid_vec;
    assign w_pop       = valid_out && ready_in;
    assign w_multi     = |(valid_vec & (valid_vec - NUM_PE'(1)));
    assign w_load      = (r_state == IDLE) && start && (len != '0);
    assign w_count_nxt = r_count + 2'(w_accept) - 2'(w_pop);
    assign valid_out   = (r_count != 2'd0);
    assign data_out    = r_mem[r_head];
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign err         = r_err;

    // Descending scan so the lowest-index asserted PE wins.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_PE - 1; i >= 0; i--)
            if (valid_vec[i]) w_sel = data_vec[i*DATA_SIZE +: DATA_SIZE];
    end

    // done is raised together with the IDLE transition so busy falls as done rises.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_load ? RUN : IDLE;
                w_done_nxt  = start && (len == '0);
            end
            RUN:   w_state_nxt = (w_accept && r_remaining == LEN_BITS'(1)) ? DRAIN : RUN;
            DRAIN: begin
                w_state_nxt = (w_count_nxt == 2'd0) ? IDLE : DRAIN;
                w_done_nxt  = (w_count_nxt == 2'd0);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_load ? 1'b0 : (r_err || (w_accept && w_multi));
            r_remaining <= w_load ? len : (w_accept ? r_remaining - LEN_BITS'(1) : r_remaining);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) r_mem[r_tail] <= w_sel;
            r_tail  <= r_tail ^ w_accept;
            r_head  <= r_head ^ w_pop;
            r_count <= w_count_nxt;
        end
    end
endmodule

// File: tb/tb_gon_row_collector.sv
// tb_gon_row_collector: table-driven cycle vectors plus hand-written reset/start sequences.
module tb_gon_row_collector;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  len;
    logic [7:0]   valid_vec;
    logic [255:0] data_vec;
    logic         ready_out, valid_out, ready_in, busy, done, err;
    logic [31:0]  data_out;

    int errors = 0;
    int checks = 0;

    gon_row_collector dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .valid_vec(valid_vec), .data_vec(data_vec),
        .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
        .ready_in(ready_in), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [15:0] ln;
        logic [7:0]  vv;
        logic [31:0] d;
        logic [31:0] d7;
        logic        rdy;
        logic        ro;
        logic        vo;
        logic [31:0] dout;
        logic        bsy;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic [15:0] ln, input logic [7:0] vv,
                       input logic [31:0] d, input logic [31:0] d7, input logic rdy,
                       input logic ro, input logic vo, input logic [31:0] dout,
                       input logic bsy, input logic dn, input logic er);
        tbl.push_back('{st, ln, vv, d, d7, rdy, ro, vo, dout, bsy, dn, er});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // PE7 carries d7, every other PE carries d.
    task automatic drive(input logic st, input logic [15:0] ln, input logic [7:0] vv,
                         input logic [31:0] d, input logic [31:0] d7, input logic rdy);
        start = st;
        len = ln;
        valid_vec = vv;
        ready_in = rdy;
        for (int i = 0; i < 8; i++) data_vec[i*32 +: 32] = (i == 7) ? d7 : d;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " ro"}, 32'(ready_out), 0);
        chk({nm, " vo"}, 32'(valid_out), 0);
        chk({nm, " do"}, data_out, 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " err"}, 32'(err), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // stream: len=4 from PE2, ready_in high
        add(1, 4, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h04, 1, 1, 1,   1, 0, 0, 1, 0, 0);
        add(0, 0, 8'h04, 2, 2, 1,   1, 1, 1, 1, 0, 0);
        add(0, 0, 8'h04, 3, 3, 1,   1, 1, 2, 1, 0, 0);
        add(0, 0, 8'h04, 4, 4, 1,   1, 1, 3, 1, 0, 0);
        add(0, 0, 8'h04, 5, 5, 1,   0, 1, 4, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        // backpressure: len=3, ready_in low then released
        add(1, 3, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h04, 32'h11, 32'h11, 0,   1, 0, 0, 1, 0, 0);
        add(0, 0, 8'h04, 32'h12, 32'h12, 0,   1, 1, 32'h11, 1, 0, 0);
        add(0, 0, 8'h04, 32'h13, 32'h13, 0,   0, 1, 32'h11, 1, 0, 0);
        add(0, 0, 8'h04, 32'h13, 32'h13, 0,   0, 1, 32'h11, 1, 0, 0);
        add(0, 0, 8'h04, 32'h13, 32'h13, 0,   0, 1, 32'h11, 1, 0, 0);
        add(0, 0, 8'h04, 32'h13, 32'h13, 0,   0, 1, 32'h11, 1, 0, 0);
        add(0, 0, 8'h04, 32'h13, 32'h13, 1,   0, 1, 32'h11, 1, 0, 0);
        add(0, 0, 8'h04, 32'h13, 32'h13, 1,   1, 1, 32'h12, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 1, 32'h13, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        // conflict PE4/PE7, err sticky until the next start
        add(1, 1, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h90, 32'hA, 32'hB, 1,   1, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 1, 32'hA, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 1);
        add(1, 1, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        add(0, 0, 8'h01, 32'h5, 32'h5, 1,   1, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 1, 32'h5, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 0);
        // len=0
        add(1, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        // start while busy (RUN then DRAIN) is ignored
        add(1, 2, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h90, 32'h21, 32'h22, 0,   1, 0, 0, 1, 0, 0);
        add(1, 7, 8'h00, 0, 0, 0,   1, 1, 32'h21, 1, 0, 1);
        add(0, 0, 8'h04, 32'h23, 32'h23, 0,   1, 1, 32'h21, 1, 0, 1);
        add(1, 7, 8'h00, 0, 0, 1,   0, 1, 32'h21, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 1,   0, 1, 32'h23, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 1);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 0, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].st, tbl[k].ln, tbl[k].vv, tbl[k].d, tbl[k].d7, tbl[k].rdy);
            chk($sformatf("row%0d ro", k), 32'(ready_out), 32'(tbl[k].ro));
            chk($sformatf("row%0d vo", k), 32'(valid_out), 32'(tbl[k].vo));
            if (tbl[k].vo) chk($sformatf("row%0d do", k), data_out, tbl[k].dout);
            chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].bsy));
            chk($sformatf("row%0d done", k), 32'(done), 32'(tbl[k].dn));
            chk($sformatf("row%0d err", k), 32'(err), 32'(tbl[k].er));
        end

        // asynchronous reset with two beats buffered and err set
        @(negedge clk); drive(1, 5, 8'h00, 0, 0, 0);
        @(negedge clk); drive(0, 0, 8'h90, 32'h31, 32'h32, 0);
        @(negedge clk); drive(0, 0, 8'h04, 32'h33, 32'h33, 0);
        @(negedge clk); drive(0, 0, 8'h00, 0, 0, 0);
        chk("pre_rst vo", 32'(valid_out), 1);
        chk("pre_rst ro", 32'(ready_out), 0);
        chk("pre_rst err", 32'(err), 1);
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst c%0d done", c), 32'(done), 0);
            chk($sformatf("post_rst c%0d busy", c), 32'(busy), 0);
        end
        @(negedge clk); drive(1, 1, 8'h00, 0, 0, 1);
        @(negedge clk); drive(0, 0, 8'h04, 32'h44, 32'h44, 1);
        chk("new ro", 32'(ready_out), 1);
        @(negedge clk); drive(0, 0, 8'h00, 0, 0, 1);
        chk("new vo", 32'(valid_out), 1);
        chk("new do", data_out, 32'h44);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        chk("new done", 32'(seen), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
